sram_mem_controller: RTL
========================

// Module: sram_mem_controller
// PURPOSE
//  Sequences 32-bit data-memory accesses from the MEM stage onto the external 16-bit SRAM.
//  Each word takes two SRAM half-word cycles plus a programmable settle wait.
//  Drives `ready` low while busy; the hazard/freeze logic stalls the pipeline on !ready.
//  Sits between the MEM-stage mem_read/mem_write controls and the SRAM pins.
// PARAMETERS
//  WAIT_CYCLES  2     extra settle cycles after the two half-word cycles (>=1)
//  BASE_ADDR    1024  ARM data address that maps to SRAM word 0
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  rd_en       in   1   MEM-stage mem_read
//  wr_en       in   1   MEM-stage mem_write
//  address     in   32  byte address from the ALU result (word aligned)
//  writeData   in   32  store data (Val_Rm)
//  readData    out  32  load data; registered
//  ready       out  1   1 = MEM stage may advance
//  SRAM_DQ     inout 16 SRAM data bus
//  SRAM_ADDR   out  18  SRAM half-word address
//  SRAM_WE_N   out  1   write enable, active low
//  SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out 1  tied 0 (always enabled)
// BEHAVIOUR
//  Reset / idle values:
//   - state=IDLE, readData=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, wait counter=0.
//  Address mapping:
//   - word = (address - BASE_ADDR)[18:2], 17 bits; offset wraps modulo 2^19, no range check.
//   - low half at SRAM_ADDR={word,0}, high half at {word,1}.
//  FSM: IDLE -> LO -> HI -> WAIT -> DONE -> IDLE.
//   - IDLE: goes to LO when rd_en|wr_en, else stays. The request is latched at this edge:
//     address, data, op. If rd_en&wr_en, write wins.
//   - LO:   SRAM_ADDR = low half address.
//           Write: DQ=wdata[15:0], WE_N=0. Read: DQ=Z, readData[15:0] <= DQ at end of cycle.
//   - HI:   same as LO for the high half, using wdata[31:16] / readData[31:16].
//   - WAIT: WE_N=1, DQ=Z. Counts WAIT_CYCLES cycles, then goes to DONE.
//   - DONE: one cycle, then IDLE.
//  ready (combinational):
//   - 1 when state==DONE, or when state==IDLE && !(rd_en|wr_en); else 0.
//  Latency:
//   - Request first seen in cycle 0 gives ready=1 in cycle 3+WAIT_CYCLES (5 at default).
//   - The pipeline advances on that edge.
//   - A back-to-back request is seen in the following IDLE cycle, costing 1 idle cycle/access.
//  Requests are sampled only in IDLE. Changes to rd_en/wr_en/address mid-access are ignored.
//  readData:
//   - Updates only during read LO/HI cycles.
//   - Stable from DONE until the next read's LO cycle. Writes never change it.
//  Reset mid-access:
//   - Back to IDLE next edge with WE_N=1 and DQ=Z. A partial write may leave half a word; accepted.
//  WE_N is never 0 outside LO/HI of a write. DQ is driven only while WE_N=0.
// STRUCTURE
//  Shared package:
//   - state encoding localparams (IDLE/LO/HI/WAIT/DONE, 3 bits)
//   - SRAM_ADDR_W=18, SRAM_DATA_W=16, BASE_ADDR default.
//  RTL:
//   - Single flat module: FSM, wait counter, request latch, tri-state driver. No RTL sub-module.
//  Bench:
//   - Bench-only sub-module sram_model: 2^18 x 16 array, async read, write on WE_N low.
// TESTING
//  1 Idle: rd_en=wr_en=0 for 10 cycles -> ready=1, WE_N=1, DQ=Z, readData=0.
//  2 Store: wr_en, address=1024, writeData=0x12345678.
//    -> LO: SRAM_ADDR=0, DQ=0x5678, WE_N=0.
//    -> HI: SRAM_ADDR=1, DQ=0x1234.
//    -> ready=1 exactly in cycle 5; model mem[0]=0x5678, mem[1]=0x1234.
//  3 Load: rd_en, address=1024 after test 2 -> ready in cycle 5, readData=0x12345678.
//    -> readData holds through the following write to 1028.
//  4 Mapping: store 0xDEADBEEF at 1028 -> writes SRAM_ADDR 2,3. Load 1028 -> 0xDEADBEEF.
//    -> 1024 still reads 0x12345678.
//  5 Conflict/stability:
//    -> rd_en=wr_en=1, address=1032, data 0xA5A5A5A5 -> write performed.
//    -> Address changed to 1036 during LO -> SRAM_ADDR stays 4/5.
//  6 Reset: rst=1 during HI of a write -> next cycle IDLE, WE_N=1, DQ=Z, ready follows requests.
//    -> A fresh load then completes in 5 cycles.
//  Also run WAIT_CYCLES=1 and 4 -> ready latency 4 and 7 cycles.

Source files
------------

// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding,
// SRAM bus widths and the default address map.
package sram_mem_controller_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WORD_W      = 17;

  localparam int          DEFAULT_WAIT_CYCLES = 2;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Half-word SRAM address of one half of a 32-bit word.
  function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [WORD_W-1:0] word,
                                                       input logic hi);
    return {word, hi};
  endfunction

endpackage

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM cycles
// (low half, then high half), followed by a settle wait and a one-cycle
// DONE in which ready releases the pipeline.
// SRAM pin values are registered: they are computed for the state being
// entered, so they are clean for the whole of each LO/HI cycle.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t                   state;
  state_t                   next_state;
  logic [CNT_W-1:0]         wait_cnt;

  // Latched request (captured on the IDLE edge that accepts it).
  logic [WORD_W-1:0]        req_word;
  logic [31:0]              req_wdata;
  logic                     req_write;

  // Incoming address mapped to an SRAM word; the offset wraps mod 2^19.
  logic [31:0]              offset;
  logic [WORD_W-1:0]        in_word;
  logic                     unused_offset_bits;

  // Pin values for the state being entered.
  logic [SRAM_ADDR_W-1:0]   nx_addr;
  logic                     nx_we_n;
  logic [SRAM_DATA_W-1:0]   nx_dq;
  logic [SRAM_DATA_W-1:0]   dq_out;

  logic                     req_any;

  assign req_any            = rd_en | wr_en;
  assign offset             = address - BASE_ADDR;
  assign in_word            = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // The chip is permanently selected with both byte lanes enabled.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // The bus is driven exactly while a write strobe is active.
  assign SRAM_DQ = SRAM_WE_N ? {SRAM_DATA_W{1'bz}} : dq_out;

  // ready: DONE releases the stage; an idle controller with no request never stalls.
  always_comb begin
    ready = 1'b0;
    if (state == ST_DONE) begin
      ready = 1'b1;
    end else if (state == ST_IDLE && !req_any) begin
      ready = 1'b1;
    end else begin
      ready = 1'b0;
    end
  end

  // Next state and the SRAM pin values that go with it.
  always_comb begin
    next_state = state;
    nx_addr    = {SRAM_ADDR_W{1'b0}};
    nx_we_n    = 1'b1;
    nx_dq      = {SRAM_DATA_W{1'b0}};
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          next_state = ST_LO;
          nx_addr    = half_addr(in_word, 1'b0);
          nx_we_n    = ~wr_en;
          nx_dq      = writeData[15:0];
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_LO: begin
        next_state = ST_HI;
        nx_addr    = half_addr(req_word, 1'b1);
        nx_we_n    = ~req_write;
        nx_dq      = req_wdata[31:16];
      end
      ST_HI: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register, settle counter and registered SRAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= {CNT_W{1'b0}};
      SRAM_ADDR <= {SRAM_ADDR_W{1'b0}};
      SRAM_WE_N <= 1'b1;
      dq_out    <= {SRAM_DATA_W{1'b0}};
    end else begin
      state     <= next_state;
      SRAM_ADDR <= nx_addr;
      SRAM_WE_N <= nx_we_n;
      dq_out    <= nx_dq;
      if (state == ST_WAIT && next_state == ST_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= {CNT_W{1'b0}};
      end
    end
  end

  // Request latch: later changes on the MEM-stage inputs are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_word  <= {WORD_W{1'b0}};
      req_wdata <= 32'd0;
      req_write <= 1'b0;
    end else if (state == ST_IDLE && req_any) begin
      req_word  <= in_word;
      req_wdata <= writeData;
      req_write <= wr_en;
    end else begin
      req_word  <= req_word;
      req_wdata <= req_wdata;
      req_write <= req_write;
    end
  end

  // Load data: each half is captured at the end of its read cycle and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      readData <= 32'd0;
    end else if (state == ST_LO && !req_write) begin
      readData[15:0] <= SRAM_DQ;
    end else if (state == ST_HI && !req_write) begin
      readData[31:16] <= SRAM_DQ;
    end else begin
      readData <= readData;
    end
  end

endmodule
